avalon_mem_slave: RTL
=====================

Name: avalon_mem_slave

Overview:
- Avalon-MM slave memory model. Responds to the master-side signals watched by the Avalon protocol checker: waitrequest wait-states, pipelined reads with readdatavalid, and byte-enabled writes.
- Sits directly downstream of the test master in the ex05 bench, so checker assertions run against a live, configurable slave.
- Also flags master-side protocol violations on a sticky error output.

Parameters:
- NBDATABYTES, 2, data bus width in bytes; data width DW = 8*NBDATABYTES.
- NBADDRBITS, 8, word address width; memory depth = 2^NBADDRBITS words.
- WAITSTATES, 2, waitrequest cycles inserted before each transfer is accepted (0..15).
- READLATENCY, 1, cycles from read acceptance to readdatavalid (1..8).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- address  in  NBADDRBITS  word address
- byteenable  in  NBDATABYTES  per-byte write enable (ignored on reads)
- writedata  in  DW  write data
- read  in  1  read request
- write  in  1  write request
- readdata  out  DW  read return data
- waitrequest  out  1  slave stall
- readdatavalid  out  1  readdata valid strobe, one cycle per accepted read
- protocol_error  out  1  sticky violation flag

Behaviour:
- Reset (rst=0, async):
  - wait counter wcnt=0; read pipeline valid bits=0.
  - readdata=0, readdatavalid=0, protocol_error=0.
  - All memory words cleared to 0.
  - A reset mid-transfer aborts the transfer; in-flight reads never produce readdatavalid.
- Definitions:
  - req = read | write.
  - waitrequest = req & (wcnt < WAITSTATES), combinational from the request.
  - waitrequest is never high while req is low.
  - WAITSTATES=0 keeps waitrequest constant 0.
- Wait counter:
  - Each cycle with req & waitrequest: wcnt increments.
  - On acceptance (req & !waitrequest): wcnt returns to 0.
  - So every transfer sees exactly WAITSTATES stall cycles and is accepted on cycle WAITSTATES+1.
- Write acceptance: at the accepting edge, byte i of mem[address] is replaced by writedata[8i+7:8i] where byteenable[i]=1. Other bytes keep their value.
- Read acceptance:
  - mem[address] is sampled at the accepting edge and enters a READLATENCY-deep shift pipeline with a valid bit.
  - READLATENCY cycles later, readdata is loaded and readdatavalid=1 for exactly one cycle.
  - Reads may be accepted back-to-back (WAITSTATES=0): one readdatavalid per read, in order, no gaps or drops.
  - readdata holds its last returned value while readdatavalid=0.
- Ordering: a read accepted in any cycle after a write acceptance returns the written data.
- Simultaneous read & write: the write is performed and the read is ignored (no readdatavalid); protocol_error set.
- Stability during stall: while waitrequest=1, a change in address, byteenable, writedata, read or write relative to the previous cycle sets protocol_error.
  - The master dropping req during a stall also resets wcnt to 0.
  - The transfer is then not performed.
- protocol_error: sticky; cleared only by reset.
- Address is word-granular; all 2^NBADDRBITS addresses are valid, with no wrap logic needed.

Test Plan:
1. Reset, then WAITSTATES=2: write 0xBEEF to addr 0x10, byteenable=2'b11 -> waitrequest high 2 cycles, accepted on 3rd cycle. Then read 0x10 -> readdatavalid 1 cycle after acceptance, readdata=0xBEEF, protocol_error=0.
2. Byte enable: mem[0x05]=0x1234, write 0xABCD with byteenable=2'b01 -> read returns 0x12CD. With byteenable=2'b00 -> value unchanged.
3. Pipelined reads, WAITSTATES=0, READLATENCY=3: read addrs 0,1,2,3 on consecutive cycles (preloaded 0x0A..0x0D) -> readdatavalid high 4 consecutive cycles starting 3 cycles after the first read, data 0x0A,0x0B,0x0C,0x0D in order.
4. Stability violation, WAITSTATES=3: change address during the 2nd stall cycle -> protocol_error=1 next cycle and stays 1. Drop read mid-stall -> no readdatavalid, wcnt restarts.
5. read=write=1 at addr 0x20 with writedata 0x5555 -> mem[0x20]=0x5555, no readdatavalid, protocol_error=1.
6. Async reset asserted between read acceptance and readdatavalid (READLATENCY=4) -> readdatavalid never pulses; after release, read of previously written address returns 0x0000.

Source files
------------

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave memory model: fixed wait-states, pipelined reads with
// readdatavalid, byte-enabled writes, and a sticky master protocol-error flag.
module avalon_mem_slave #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WAITSTATES  = 2,
  parameter int READLATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    address,
  input  logic [NBDATABYTES-1:0]   byteenable,
  input  logic [8*NBDATABYTES-1:0] writedata,
  input  logic                     read,
  input  logic                     write,
  output logic [8*NBDATABYTES-1:0] readdata,
  output logic                     waitrequest,
  output logic                     readdatavalid,
  output logic                     protocol_error
);

  localparam int DW    = 8 * NBDATABYTES;
  localparam int DEPTH = 1 << NBADDRBITS;

  logic [DW-1:0]          mem [DEPTH];
  logic [4:0]             wcnt;
  logic                   req;
  logic                   stall;
  logic                   accept;
  logic                   acc_wr;
  logic                   acc_rd;
  logic [DW-1:0]          bemask;

  logic                   prev_stall;
  logic [NBADDRBITS-1:0]  p_addr;
  logic [NBDATABYTES-1:0] p_be;
  logic [DW-1:0]          p_wd;
  logic                   p_rd;
  logic                   p_wr;
  logic                   changed;

  assign req = read | write;

  generate
    if (WAITSTATES == 0) begin : g_nowait
      assign stall = 1'b0;
    end else begin : g_wait
      assign stall = (wcnt < 5'(WAITSTATES));
    end
  endgenerate

  assign waitrequest = req & stall;
  assign accept      = req & ~stall;
  // A simultaneous read and write performs only the write.
  assign acc_wr      = accept & write;
  assign acc_rd      = accept & read & ~write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (!req || !stall) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 5'd1;
    end
  end

  for (genvar g = 0; g < NBDATABYTES; g++) begin : g_bemask
    assign bemask[8*g +: 8] = {8{byteenable[g]}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (acc_wr) begin
      mem[address] <= (mem[address] & ~bemask) | (writedata & bemask);
    end
  end

  // Read pipeline: stage g is fed by stage g-1 (stage 0 by the accepted read);
  // data only advances with a valid bit, so the last stage holds readdata.
  logic          pv [READLATENCY];
  logic [DW-1:0] pd [READLATENCY];
  logic          sv [READLATENCY];
  logic [DW-1:0] sd [READLATENCY];

  for (genvar g = 0; g < READLATENCY; g++) begin : g_pipe
    if (g == 0) begin : g_head
      assign sv[g] = acc_rd;
      assign sd[g] = mem[address];
    end else begin : g_tail
      assign sv[g] = pv[g-1];
      assign sd[g] = pd[g-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv[g] <= 1'b0;
        pd[g] <= '0;
      end else begin
        pv[g] <= sv[g];
        if (sv[g]) begin
          pd[g] <= sd[g];
        end
      end
    end
  end

  assign readdata      = pd[READLATENCY-1];
  assign readdatavalid = pv[READLATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_stall <= 1'b0;
      p_addr     <= '0;
      p_be       <= '0;
      p_wd       <= '0;
      p_rd       <= 1'b0;
      p_wr       <= 1'b0;
    end else begin
      prev_stall <= waitrequest;
      p_addr     <= address;
      p_be       <= byteenable;
      p_wd       <= writedata;
      p_rd       <= read;
      p_wr       <= write;
    end
  end

  // Any master signal moving after a stalled cycle is a violation, including
  // dropping the request altogether.
  assign changed = prev_stall &&
                   ((address != p_addr) || (byteenable != p_be) ||
                    (writedata != p_wd) || (read != p_rd) || (write != p_wr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      protocol_error <= 1'b0;
    end else if (changed || (read && write)) begin
      protocol_error <= 1'b1;
    end
  end

endmodule
